// File: rtl/difftest_step_batcher_if.sv
// difftest_step_batcher_if
//   Bundles the commit-side inputs and the batch outputs of difftest_step_batcher.
//   master : drives commit_valid/commit_cnt/flush/simv_result, observes the outputs
//   slave  : the batcher itself
//   commit_valid  commit_cnt is valid this cycle
//   commit_cnt    instructions committed this cycle
//   flush         emit any pending count now
//   simv_result   deferred result from the step controller, non-zero = halt
//   step          batch size, non-zero for one cycle per batch
//   halted        sticky halt indication
//   emit_count    batches emitted since reset (wraps)
//   dropped_cnt   commits discarded while halted (saturates)
interface difftest_step_batcher_if #(
    parameter int STEP_WIDTH = 8,
    parameter int IN_WIDTH   = 4
);
    logic                  commit_valid;
    logic [IN_WIDTH-1:0]   commit_cnt;
    logic                  flush;
    logic [7:0]            simv_result;
    logic [STEP_WIDTH-1:0] step;
    logic                  halted;
    logic [31:0]           emit_count;
    logic [31:0]           dropped_cnt;

    modport master (
        output commit_valid, commit_cnt, flush, simv_result,
        input  step, halted, emit_count, dropped_cnt
    );

    modport slave (
        input  commit_valid, commit_cnt, flush, simv_result,
        output step, halted, emit_count, dropped_cnt
    );
endinterface

// File: rtl/difftest_step_batcher.sv
// difftest_step_batcher
//   Accumulates per-cycle commit counts into batches and emits one registered,
//   non-zero step pulse per batch (threshold, idle timeout or flush). Once the
//   deferred simv_result goes non-zero the block halts for good (until reset)
//   and only counts the commits it throws away.
// Ports
//   clock_i  system clock
//   reset_i  asynchronous active-high reset
//   bus      difftest_step_batcher_if.slave (commit inputs, step/status outputs)
module difftest_step_batcher #(
    parameter int STEP_WIDTH      = 8,
    parameter int IN_WIDTH        = 4,
    parameter int BATCH_THRESHOLD = 16,
    parameter int TIMEOUT         = 64
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    difftest_step_batcher_if.slave  bus
);

    // The accumulator can hold at most THRESHOLD-1, plus one max input,
    // which must still fit in STEP_WIDTH bits.
    if (BATCH_THRESHOLD < 1 || TIMEOUT < 1 ||
        (BATCH_THRESHOLD - 1) + (2**IN_WIDTH - 1) > (2**STEP_WIDTH - 1)) begin : g_param_chk
        $error("difftest_step_batcher: illegal parameter combination");
    end

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]         TMAX = TW'(TIMEOUT - 1);
    localparam logic [STEP_WIDTH-1:0] THR  = STEP_WIDTH'(BATCH_THRESHOLD);

    typedef enum logic [1:0] {IDLE, ACCUM, HALTED} state_t;

    state_t                state_q, state_d;
    logic [STEP_WIDTH-1:0] acc_q, acc_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [STEP_WIDTH-1:0] step_q, step_d;
    logic [31:0]           emit_q, emit_d;
    logic [31:0]           drop_q, drop_d;

    logic [IN_WIDTH-1:0]   in_w;
    logic [STEP_WIDTH-1:0] sum;
    logic [32:0]           drop_sum;
    logic                  emit;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            acc_q   <= '0;
            timer_q <= '0;
            step_q  <= '0;
            emit_q  <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            timer_q <= timer_d;
            step_q  <= step_d;
            emit_q  <= emit_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        in_w     = bus.commit_valid ? bus.commit_cnt : '0;
        sum      = acc_q + STEP_WIDTH'(in_w);
        drop_sum = {1'b0, drop_q} + 33'(in_w);
        // Timer counts cycles since the batch opened; incoming commits never restart it.
        emit     = (sum >= THR) || (bus.flush && sum != '0) ||
                   (state_q == ACCUM && timer_q == TMAX);

        state_d  = state_q;
        acc_d    = acc_q;
        timer_d  = timer_q;
        step_d   = '0;
        emit_d   = emit_q;
        drop_d   = drop_q;

        case (state_q)
            HALTED: begin
                acc_d   = '0;
                timer_d = '0;
                drop_d  = drop_sum[32] ? '1 : drop_sum[31:0];
            end
            default: begin
                if (bus.simv_result != '0) begin
                    // Halt beats any coincident emit condition.
                    state_d = HALTED;
                    acc_d   = '0;
                    timer_d = '0;
                end else if (emit) begin
                    step_d  = sum;
                    acc_d   = '0;
                    timer_d = '0;
                    emit_d  = emit_q + 32'd1;
                    state_d = IDLE;
                end else begin
                    acc_d   = sum;
                    state_d = (sum != '0) ? ACCUM : IDLE;
                    // In ACCUM without an emit the timer is below TMAX, so +1 cannot wrap.
                    timer_d = (state_q == ACCUM && sum != '0) ? timer_q + TW'(1) : '0;
                end
            end
        endcase
    end

    assign bus.step        = step_q;
    assign bus.halted      = (state_q == HALTED);
    assign bus.emit_count  = emit_q;
    assign bus.dropped_cnt = drop_q;

endmodule

// File: tb/tb_difftest_step_batcher.sv
module tb_difftest_step_batcher;
    localparam int SW  = 8;
    localparam int IW  = 4;
    localparam int THR = 16;
    localparam int TO  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    difftest_step_batcher_if #(.STEP_WIDTH(SW), .IN_WIDTH(IW)) bus ();

    difftest_step_batcher #(
        .STEP_WIDTH(SW), .IN_WIDTH(IW), .BATCH_THRESHOLD(THR), .TIMEOUT(TO)
    ) dut (
        .clock_i (clk),
        .reset_i (rst),
        .bus     (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: pending total plus the cycle stamp at which the batch opened.
    longint m_acc, m_start, m_cyc, m_step, m_emits, m_drop;
    bit     m_halt;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_acc = 0; m_start = 0; m_step = 0; m_emits = 0; m_drop = 0; m_halt = 0;
    endtask

    task automatic model_edge(input bit v, input int c, input bit f, input int r);
        longint inn, tot;
        inn = v ? c : 0;
        if (m_halt) begin
            m_step = 0;
            m_drop = (m_drop + inn > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_drop + inn;
        end else if (r != 0) begin
            m_halt = 1; m_step = 0; m_acc = 0;
        end else begin
            tot = m_acc + inn;
            if (tot >= THR || (f && tot != 0) || (m_acc != 0 && m_cyc - m_start == TO)) begin
                m_step = tot; m_acc = 0; m_emits = (m_emits + 1) % 64'h1_0000_0000;
            end else begin
                m_step = 0;
                if (m_acc == 0 && tot != 0) m_start = m_cyc;
                m_acc = tot;
            end
        end
        m_cyc++;
    endtask

    task automatic compare_model(input string tag);
        chk({tag, ".step"},    bus.step,        m_step);
        chk({tag, ".halted"},  bus.halted,      m_halt);
        chk({tag, ".emits"},   bus.emit_count,  m_emits);
        chk({tag, ".dropped"}, bus.dropped_cnt, m_drop);
    endtask

    // Called at a negedge: apply inputs, let one posedge happen, check at next negedge.
    task automatic cycle(input bit v, input int c, input bit f, input int r, input string tag);
        bus.commit_valid = v;
        bus.commit_cnt   = IW'(c);
        bus.flush        = f;
        bus.simv_result  = 8'(r);
        @(posedge clk);
        model_edge(v, c, f, r);
        @(negedge clk);
        compare_model(tag);
    endtask

    task automatic do_reset(input string tag);
        bus.commit_valid = 0; bus.commit_cnt = '0; bus.flush = 0; bus.simv_result = '0;
        rst = 1'b1;
        #1;
        model_reset();
        compare_model(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        bit v; int c; bit f; int r; int es; int ee; string nm;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(bit v, int c, bit f, int r, int es, int ee, string nm);
        vec_t x;
        x.v = v; x.c = c; x.f = f; x.r = r; x.es = es; x.ee = ee; x.nm = nm;
        return x;
    endfunction

    initial begin
        longint total;
        // T1 threshold, T2 timeout, T3 flush: expected step and emit_count after each edge
        tbl.push_back(mk(1, 5, 0, 0,  0, 0, "t1a"));
        tbl.push_back(mk(1, 5, 0, 0,  0, 0, "t1b"));
        tbl.push_back(mk(1, 5, 0, 0,  0, 0, "t1c"));
        tbl.push_back(mk(1, 5, 0, 0, 20, 1, "t1d"));
        tbl.push_back(mk(1, 3, 0, 0,  0, 1, "t2a"));
        tbl.push_back(mk(0, 0, 0, 0,  0, 1, "t2b"));
        tbl.push_back(mk(0, 0, 0, 0,  0, 1, "t2c"));
        tbl.push_back(mk(0, 0, 0, 0,  0, 1, "t2d"));
        tbl.push_back(mk(0, 0, 0, 0,  3, 2, "t2e"));
        tbl.push_back(mk(0, 0, 0, 0,  0, 2, "t2f"));
        tbl.push_back(mk(1, 7, 0, 0,  0, 2, "t3a"));
        tbl.push_back(mk(1, 2, 1, 0,  9, 3, "t3b"));
        tbl.push_back(mk(0, 0, 1, 0,  0, 3, "t3c"));
        tbl.push_back(mk(1, 0, 1, 0,  0, 3, "t3d"));

        @(negedge clk);
        m_cyc = 0;
        do_reset("reset");

        foreach (tbl[i]) begin
            cycle(tbl[i].v, tbl[i].c, tbl[i].f, tbl[i].r, tbl[i].nm);
            chk({tbl[i].nm, ".tbl_step"},  bus.step,       tbl[i].es);
            chk({tbl[i].nm, ".tbl_emits"}, bus.emit_count, tbl[i].ee);
        end

        // T5: async reset with acc=10 pending
        cycle(1, 10, 0, 0, "t5a");
        bus.commit_valid = 0; bus.commit_cnt = '0;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("t5.step",   bus.step,       0);
        chk("t5.emits",  bus.emit_count, 0);
        chk("t5.halted", bus.halted,     0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) cycle(0, 0, 0, 0, "t5idle");

        // T4: halt beats a coincident threshold emit
        cycle(1, 6, 0, 0, "t4a");
        cycle(1, 6, 0, 0, "t4b");
        cycle(1, 6, 1, 1, "t4halt");
        chk("t4.halted", bus.halted, 1);
        chk("t4.step",   bus.step,   0);
        for (int k = 0; k < 3; k++) cycle(1, 5, 0, 1, "t4drop");
        chk("t4.dropped", bus.dropped_cnt, 15);
        for (int k = 0; k < 5; k++) cycle(0, 0, 1, 0, "t4stay");
        chk("t4.sticky", bus.halted, 1);
        chk("t4.emits",  bus.emit_count, 0);

        // T6: max load, conservation of committed count
        do_reset("t6rst");
        total = 0;
        for (int k = 0; k < 20; k++) begin
            cycle(1, 15, 0, 0, "t6");
            total += bus.step;
        end
        cycle(0, 0, 1, 0, "t6flush");
        total += bus.step;
        chk("t6.total", total, 300);
        chk("t6.emits", bus.emit_count, 10);

        // Randomized traffic against the model
        do_reset("rndrst");
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 199) == 0) do_reset("rndrst2");
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 15), $urandom_range(0, 7) == 0,
                  ($urandom_range(0, 149) == 0) ? $urandom_range(1, 255) : 0, "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
